// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the single FIFO write port between N_REQ byte producers.
// Define CRC_APPEND_EN to append a per-channel CRC-8 byte after every FRAME_LEN data bytes.
module fifo_write_arbiter #(
  parameter int N_REQ     = 4,
  parameter int FRAME_LEN = 4,
  parameter int IDW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic               fifo_busy,
  output logic [N_REQ-1:0]   ack,
  output logic               fifo_we,
  output logic [7:0]         fifo_data,
  output logic [IDW-1:0]     grant_id,
  output logic               busy
);

  if (N_REQ < 2 || N_REQ > 8 || FRAME_LEN < 1) begin : g_param_check
    $error("fifo_write_arbiter: N_REQ must be 2..8 and FRAME_LEN >= 1");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_WRITE,
    ST_CRC_WAIT,
    ST_CRC_WRITE
  } state_e;

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic               fifo_we_q, fifo_we_d;
  logic [7:0]         fifo_data_q, fifo_data_d;
  logic [IDW-1:0]     grant_id_q, grant_id_d;
  logic [IDW-1:0]     last_grant_q, last_grant_d;
  logic               busy_q;
  logic [7:0]         hold_q, hold_d;
  logic               hold_load;

  // Round-robin pick: lowest requester above last_grant, else lowest overall (wrap).
  logic [N_REQ-1:0]   above_mask;
  logic [N_REQ-1:0]   masked_req;
  logic [N_REQ-1:0]   pick_src;
  logic [IDW-1:0]     winner;

  always_comb begin
    above_mask = {N_REQ{1'b1}} << (int'(last_grant_q) + 1);
    masked_req = req & above_mask;
    pick_src   = (masked_req != '0) ? masked_req : req;
    winner     = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (pick_src[i]) winner = IDW'(i);
    end
  end

`ifdef CRC_APPEND_EN
  localparam int CNT_W = $clog2(FRAME_LEN + 1);

  logic [7:0]       crc_q [N_REQ];
  logic [CNT_W-1:0] cnt_q [N_REQ];
  logic             data_wr;
  logic             crc_clr;

  // CRC-8, poly 0x07, MSB first: fold the byte in, then eight shift/reduce steps.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] d);
    logic [7:0] c;
    c = crc ^ d;
    for (int b = 0; b < 8; b++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction
`endif

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    ack_d        = '0;
    fifo_we_d    = 1'b0;
    fifo_data_d  = fifo_data_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    hold_load    = 1'b0;
    hold_d       = req_data[8*winner +: 8];
`ifdef CRC_APPEND_EN
    data_wr      = 1'b0;
    crc_clr      = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (enable && (req != '0)) begin
          ack_d        = N_REQ'(1) << winner;
          grant_id_d   = winner;
          last_grant_d = winner;
          hold_load    = 1'b1;
          state_d      = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!fifo_busy) begin
          fifo_we_d   = 1'b1;
          fifo_data_d = hold_q;
          state_d     = ST_WRITE;
`ifdef CRC_APPEND_EN
          data_wr     = 1'b1;
`endif
        end
      end
      ST_WRITE: begin
        state_d = ST_IDLE;
`ifdef CRC_APPEND_EN
        if (cnt_q[grant_id_q] == CNT_W'(FRAME_LEN)) state_d = ST_CRC_WAIT;
`endif
      end
`ifdef CRC_APPEND_EN
      ST_CRC_WAIT: begin
        if (!fifo_busy) begin
          fifo_we_d   = 1'b1;
          fifo_data_d = crc_q[grant_id_q];
          state_d     = ST_CRC_WRITE;
        end
      end
      ST_CRC_WRITE: begin
        crc_clr = 1'b1;
        state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      ack_q        <= '0;
      fifo_we_q    <= 1'b0;
      fifo_data_q  <= '0;
      grant_id_q   <= '0;
      last_grant_q <= IDW'(N_REQ - 1);
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ack_q        <= ack_d;
      fifo_we_q    <= fifo_we_d;
      fifo_data_q  <= fifo_data_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      busy_q       <= (state_d != ST_IDLE);
    end
  end

  // NOTE: the hold byte is pure datapath, only read after it has been loaded, so it carries no reset.
  always_ff @(posedge clk) begin
    if (hold_load) hold_q <= hold_d;
  end

`ifdef CRC_APPEND_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_REQ; i++) begin
        crc_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (grant_id_q == IDW'(i)) begin
          if (data_wr) begin
            crc_q[i] <= crc8_byte(crc_q[i], hold_q);
            cnt_q[i] <= cnt_q[i] + CNT_W'(1);
          end else if (crc_clr) begin
            crc_q[i] <= '0;
            cnt_q[i] <= '0;
          end
        end
      end
    end
  end
`endif

  assign ack       = ack_q;
  assign fifo_we   = fifo_we_q;
  assign fifo_data = fifo_data_q;
  assign grant_id  = grant_id_q;
  assign busy      = busy_q;

endmodule
